// File: rtl/uart_ctrl_if.sv
// CPU register bus between the system bus decoder and uart_ctrl.
// Handshake: we and re are single-cycle strobes that are never high together. A write takes
// effect on the edge that samples it. rdata updates on the edge after re and holds otherwise.
// irq is a registered level.
interface uart_ctrl_if;
    logic [1:0]  addr;
    logic        we;
    logic        re;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (output addr, we, re, wdata, input rdata, irq);
    modport slave  (input addr, we, re, wdata, output rdata, irq);
endinterface

// File: rtl/uart_ctrl.sv
// Register-mapped UART controller: TX/RX byte FIFOs, baud divisor register and level irq,
// sequencing one transceiver through the tx_wr/tx_done and rx_done handshakes.
module uart_ctrl #(
    parameter int          DEPTH_LOG2  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd27
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    uart_ctrl_if.slave  bus,
    output logic [15:0] divisor,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_done,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic        tx_state
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    typedef enum logic {T_IDLE = 1'b0, T_WAIT = 1'b1} tx_state_t;
    tx_state_t state, state_next;

    logic [7:0]            tx_mem [DEPTH];
    logic [7:0]            rx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [DEPTH_LOG2:0]   tx_cnt, rx_cnt;
    logic                  tx_full, tx_empty, rx_full, rx_empty;
    logic                  tx_push, tx_pop, rx_push, rx_pop;
    logic                  rx_ovf, tx_ovf, tx_idle;
    logic [2:0]            irq_en;
    logic [31:0]           status;
    logic                  wr_data, wr_status, wr_div, wr_irq_en, rd_data;

    assign wr_data   = bus.we && (bus.addr == 2'd0);
    assign wr_status = bus.we && (bus.addr == 2'd1);
    assign wr_div    = bus.we && (bus.addr == 2'd2);
    assign wr_irq_en = bus.we && (bus.addr == 2'd3);
    assign rd_data   = bus.re && (bus.addr == 2'd0);

    assign tx_full  = (tx_cnt == FULL_CNT);
    assign tx_empty = (tx_cnt == '0);
    assign rx_full  = (rx_cnt == FULL_CNT);
    assign rx_empty = (rx_cnt == '0);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside a pop.
    assign tx_push = wr_data && (!tx_full || tx_pop);
    assign rx_pop  = rd_data && !rx_empty;
    assign rx_push = rx_done && (!rx_full || rx_pop);
    assign tx_idle = tx_empty && (state == T_IDLE);
    assign tx_state = state;

    always_ff @(posedge sys_clk) begin
        if (tx_push) tx_mem[tx_wp] <= bus.wdata[7:0];
        if (rx_push) rx_mem[rx_wp] <= rx_data;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + PTR_ONE;
            if (tx_pop)  tx_rp <= tx_rp + PTR_ONE;
            if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + CNT_ONE;
            else if (tx_pop && !tx_push) tx_cnt <= tx_cnt - CNT_ONE;
            if (rx_push) rx_wp <= rx_wp + PTR_ONE;
            if (rx_pop)  rx_rp <= rx_rp + PTR_ONE;
            if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + CNT_ONE;
            else if (rx_pop && !rx_push) rx_cnt <= rx_cnt - CNT_ONE;
        end
    end

    // Sticky overflow flags: a new overflow in the same cycle as a clear wins.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tx_ovf  <= 1'b0;
            rx_ovf  <= 1'b0;
            divisor <= DEFAULT_DIV;
            irq_en  <= 3'd0;
        end else begin
            if (wr_data && tx_full && !tx_pop)   tx_ovf <= 1'b1;
            else if (wr_status && bus.wdata[6])  tx_ovf <= 1'b0;
            if (rx_done && rx_full && !rx_pop)   rx_ovf <= 1'b1;
            else if (wr_status && bus.wdata[5])  rx_ovf <= 1'b0;
            if (wr_div)    divisor <= bus.wdata[15:0];
            if (wr_irq_en) irq_en  <= bus.wdata[2:0];
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= T_IDLE;
        else            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            T_IDLE:  if (!tx_empty) state_next = T_WAIT;
            T_WAIT:  if (tx_done)   state_next = T_IDLE;
            default: state_next = T_IDLE;
        endcase
    end

    always_comb begin
        tx_pop = 1'b0;
        if (state == T_IDLE && !tx_empty) tx_pop = 1'b1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tx_wr   <= 1'b0;
            tx_data <= 8'd0;
        end else begin
            tx_wr <= tx_pop;
            if (tx_pop) tx_data <= tx_mem[tx_rp];
        end
    end

    always_comb begin
        status    = '0;
        status[0] = !rx_empty;
        status[1] = rx_full;
        status[2] = tx_full;
        status[3] = tx_empty;
        status[4] = tx_idle;
        status[5] = rx_ovf;
        status[6] = tx_ovf;
        status[8 +: DEPTH_LOG2+1] = rx_cnt;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bus.rdata <= 32'd0;
            bus.irq   <= 1'b0;
        end else begin
            if (bus.re) begin
                case (bus.addr)
                    2'd0:    bus.rdata <= rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rp]};
                    2'd1:    bus.rdata <= status;
                    2'd2:    bus.rdata <= {16'd0, divisor};
                    default: bus.rdata <= {29'd0, irq_en};
                endcase
            end
            bus.irq <= (!rx_empty && irq_en[0]) || (tx_idle && irq_en[1]) ||
                       ((rx_ovf || tx_ovf) && irq_en[2]);
        end
    end
endmodule

// File: tb/tb_uart_ctrl.sv
// Bench for uart_ctrl: queue-based FIFO/flag model plus a simple transceiver stand-in.
module tb_uart_ctrl;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_ctrl_if bus();
    logic [15:0] divisor;
    logic [7:0]  tx_data, rx_data;
    logic        tx_wr, tx_done, rx_done, tx_state;

    uart_ctrl #(.DEPTH_LOG2(4), .DEFAULT_DIV(16'd27)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .bus(bus), .divisor(divisor),
        .tx_data(tx_data), .tx_wr(tx_wr), .tx_done(tx_done),
        .rx_data(rx_data), .rx_done(rx_done), .tx_state(tx_state)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_wr_cyc = 0;
    int wr_busy_cnt = 0;
    int remain = 0;
    bit busy = 0;
    bit model_run = 1;
    bit rx_ovf_m = 0;
    bit tx_ovf_m = 0;
    logic [7:0] exp_q[$];
    logic [7:0] tx_exp_q[$];
    logic [7:0] tx_got_q[$];
    int tx_wr_cyc_q[$];
    int done_cyc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Transceiver stand-in: a frame lasts 10*divisor cycles after tx_wr, then one tx_done pulse.
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (!rst_n) busy = 0;
            else if (tx_wr === 1'b1) begin
                if (busy) wr_busy_cnt++;
                tx_got_q.push_back(tx_data);
                tx_wr_cyc_q.push_back(cyc);
                busy = 1;
                remain = 10 * int'(divisor);
            end else if (busy && model_run) begin
                remain--;
                if (remain <= 0) begin
                    tx_done = 1'b1;
                    busy = 0;
                    done_cyc_q.push_back(cyc);
                end
            end
        end
    end

    function automatic logic [31:0] exp_status(int rx_n, int tx_n, bit idle);
        logic [31:0] s;
        s = '0;
        s[0] = (rx_n > 0);
        s[1] = (rx_n == DEPTH);
        s[2] = (tx_n == DEPTH);
        s[3] = (tx_n == 0);
        s[4] = idle;
        s[5] = rx_ovf_m;
        s[6] = tx_ovf_m;
        s[12:8] = 5'(rx_n);
        return s;
    endfunction

    // Driver tasks are entered on a falling edge and return on the next one.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.addr = a;
        bus.wdata = d;
        bus.we = 1'b1;
        last_wr_cyc = cyc;
        @(negedge clk);
        bus.we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus.addr = a;
        bus.re = 1'b1;
        @(negedge clk);
        bus.re = 1'b0;
        d = bus.rdata;
    endtask

    task automatic rx_inject(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else rx_ovf_m = 1;
    endtask

    task automatic wait_tx_drain(input int n);
        int t;
        t = 0;
        while ((tx_got_q.size() < n || busy) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 5000) begin
            errors++;
            $display("FAIL tx_drain_timeout got %0d bytes need %0d", tx_got_q.size(), n);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic clear_tx_model();
        tx_exp_q.delete();
        tx_got_q.delete();
        tx_wr_cyc_q.delete();
        done_cyc_q.delete();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        checks++; if (bus.rdata !== 32'd0) begin errors++; $display("FAIL rst_rdata got %h exp 0", bus.rdata); end
        checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", bus.irq); end
        checks++; if (tx_wr !== 1'b0) begin errors++; $display("FAIL rst_tx_wr got %b exp 0", tx_wr); end
        checks++; if (tx_data !== 8'd0) begin errors++; $display("FAIL rst_tx_data got %h exp 0", tx_data); end
        checks++; if (divisor !== 16'd27) begin errors++; $display("FAIL rst_divisor got %0d exp 27", divisor); end
        rst_n = 1'b1;
        @(negedge clk);
        bus_read(2'd1, d);
        checks++; if (d !== exp_status(0, 0, 1)) begin errors++; $display("FAIL rst_status got %h exp %h", d, exp_status(0, 0, 1)); end
        bus_read(2'd2, d);
        checks++; if (d !== 32'd27) begin errors++; $display("FAIL rst_div_read got %0d exp 27", d); end
        bus_read(2'd3, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL rst_irq_en got %h exp 0", d); end
        bus_read(2'd0, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL rst_empty_data got %h exp 0", d); end
    endtask

    task automatic test_divisor();
        logic [31:0] d;
        logic [15:0] v;
        v = 16'($urandom_range(1, 16'hFFFF));
        bus_write(2'd2, {16'hABCD, v});
        checks++; if (divisor !== v) begin errors++; $display("FAIL div_out got %h exp %h", divisor, v); end
        bus_read(2'd2, d);
        checks++; if (d !== {16'd0, v}) begin errors++; $display("FAIL div_read got %h exp %h", d, v); end
        bus_write(2'd2, 32'd4);
        checks++; if (divisor !== 16'd4) begin errors++; $display("FAIL div_set4 got %0d exp 4", divisor); end
    endtask

    task automatic test_tx_basic();
        logic [31:0] d;
        int w, n;
        clear_tx_model();
        model_run = 1;
        bus_write(2'd0, 32'h55);
        w = last_wr_cyc;
        bus_write(2'd0, 32'hA3);
        wait_tx_drain(2);
        checks++; if (tx_got_q.size() != 2) begin errors++; $display("FAIL tx_count got %0d exp 2", tx_got_q.size()); end
        if (tx_got_q.size() >= 2 && done_cyc_q.size() >= 1) begin
            checks++; if (tx_got_q[0] !== 8'h55) begin errors++; $display("FAIL tx_byte0 got %h exp 55", tx_got_q[0]); end
            checks++; if (tx_got_q[1] !== 8'hA3) begin errors++; $display("FAIL tx_byte1 got %h exp a3", tx_got_q[1]); end
            checks++; if (tx_wr_cyc_q[0] != w + 2) begin errors++; $display("FAIL tx_latency got %0d exp %0d", tx_wr_cyc_q[0] - w, 2); end
            checks++; if (tx_wr_cyc_q[1] - done_cyc_q[0] != 2) begin errors++; $display("FAIL tx_gap got %0d exp 2", tx_wr_cyc_q[1] - done_cyc_q[0]); end
        end
        bus_read(2'd1, d);
        checks++; if (d !== exp_status(0, 0, 1)) begin errors++; $display("FAIL tx_idle_status got %h exp %h", d, exp_status(0, 0, 1)); end
        clear_tx_model();
        n = $urandom_range(3, 10);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            tx_exp_q.push_back(b);
            bus_write(2'd0, {24'($urandom), b});
        end
        wait_tx_drain(n);
        checks++; if (tx_got_q.size() != n) begin errors++; $display("FAIL tx_rand_count got %0d exp %0d", tx_got_q.size(), n); end
        for (int i = 0; i < n && i < tx_got_q.size(); i++) begin
            checks++; if (tx_got_q[i] !== tx_exp_q[i]) begin errors++; $display("FAIL tx_rand_byte%0d got %h exp %h", i, tx_got_q[i], tx_exp_q[i]); end
        end
    endtask

    task automatic test_tx_overflow();
        logic [31:0] d;
        logic [7:0] b;
        int t;
        clear_tx_model();
        model_run = 0;
        b = 8'($urandom);
        tx_exp_q.push_back(b);
        bus_write(2'd0, {24'd0, b});
        t = 0;
        while (tx_got_q.size() < 1 && t < 20) begin @(negedge clk); t++; end
        checks++; if (tx_got_q.size() != 1) begin errors++; $display("FAIL ovf_prime got %0d exp 1", tx_got_q.size()); end
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            tx_exp_q.push_back(b);
            bus_write(2'd0, {24'd0, b});
        end
        bus_read(2'd1, d);
        checks++; if (d !== exp_status(0, 16, 0)) begin errors++; $display("FAIL tx_full_status got %h exp %h", d, exp_status(0, 16, 0)); end
        bus_write(2'd0, 32'($urandom));
        tx_ovf_m = 1;
        bus_read(2'd1, d);
        checks++; if (d !== exp_status(0, 16, 0)) begin errors++; $display("FAIL tx_ovf_status got %h exp %h", d, exp_status(0, 16, 0)); end
        bus_write(2'd1, 32'h40);
        tx_ovf_m = 0;
        bus_read(2'd1, d);
        checks++; if (d !== exp_status(0, 16, 0)) begin errors++; $display("FAIL tx_ovf_clear got %h exp %h", d, exp_status(0, 16, 0)); end
        model_run = 1;
        wait_tx_drain(17);
        checks++; if (tx_got_q.size() != 17) begin errors++; $display("FAIL ovf_drain_count got %0d exp 17", tx_got_q.size()); end
        for (int i = 0; i < 17 && i < tx_got_q.size(); i++) begin
            checks++; if (tx_got_q[i] !== tx_exp_q[i]) begin errors++; $display("FAIL ovf_byte%0d got %h exp %h", i, tx_got_q[i], tx_exp_q[i]); end
        end
    endtask

    task automatic test_rx();
        logic [31:0] d;
        logic [7:0] b;
        exp_q.delete();
        for (int i = 0; i < 17; i++) rx_inject(8'(i));
        bus_read(2'd1, d);
        checks++; if (d !== exp_status(exp_q.size(), 0, 1)) begin errors++; $display("FAIL rx_full_status got %h exp %h", d, exp_status(exp_q.size(), 0, 1)); end
        // overflow and clear in the same cycle: the flag must stay set
        bus.addr = 2'd1; bus.wdata = 32'h20; bus.we = 1'b1;
        rx_data = 8'h77; rx_done = 1'b1;
        @(negedge clk);
        bus.we = 1'b0; rx_done = 1'b0;
        rx_ovf_m = 1;
        bus_read(2'd1, d);
        checks++; if (d !== exp_status(exp_q.size(), 0, 1)) begin errors++; $display("FAIL rx_set_wins got %h exp %h", d, exp_status(exp_q.size(), 0, 1)); end
        bus_write(2'd1, 32'h20);
        rx_ovf_m = 0;
        for (int i = 0; i < 16; i++) begin
            bus_read(2'd0, d);
            b = exp_q.pop_front();
            checks++; if (d !== {24'd0, b}) begin errors++; $display("FAIL rx_read%0d got %h exp %h", i, d, b); end
        end
        bus_read(2'd0, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL rx_empty_read got %h exp 0", d); end
        bus_read(2'd1, d);
        checks++; if (d !== exp_status(0, 0, 1)) begin errors++; $display("FAIL rx_drained_status got %h exp %h", d, exp_status(0, 0, 1)); end
        for (int i = 0; i < 16; i++) rx_inject(8'($urandom));
        // push and pop together while full
        b = 8'($urandom);
        bus.addr = 2'd0; bus.re = 1'b1;
        rx_data = b; rx_done = 1'b1;
        @(negedge clk);
        bus.re = 1'b0; rx_done = 1'b0;
        d = bus.rdata;
        checks++; if (d !== {24'd0, exp_q[0]}) begin errors++; $display("FAIL rx_full_pushpop got %h exp %h", d, exp_q[0]); end
        void'(exp_q.pop_front());
        exp_q.push_back(b);
        bus_read(2'd1, d);
        checks++; if (d !== exp_status(exp_q.size(), 0, 1)) begin errors++; $display("FAIL rx_pushpop_status got %h exp %h", d, exp_status(exp_q.size(), 0, 1)); end
        while (exp_q.size() > 0) begin
            bus_read(2'd0, d);
            b = exp_q.pop_front();
            checks++; if (d !== {24'd0, b}) begin errors++; $display("FAIL rx_rand_read got %h exp %h", d, b); end
        end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        int t;
        bus_write(2'd3, 32'd1);
        rx_data = 8'h3C; rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        exp_q.push_back(8'h3C);
        checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_before_push got %b exp 0", bus.irq); end
        @(negedge clk);
        checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL irq_rx_rise got %b exp 1", bus.irq); end
        bus_read(2'd0, d);
        void'(exp_q.pop_front());
        checks++; if (d !== 32'h3C) begin errors++; $display("FAIL irq_rx_data got %h exp 3c", d); end
        checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL irq_hold_pop got %b exp 1", bus.irq); end
        @(negedge clk);
        checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_rx_fall got %b exp 0", bus.irq); end
        clear_tx_model();
        model_run = 1;
        bus_write(2'd3, 32'd2);
        repeat (2) @(negedge clk);
        checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL irq_idle got %b exp 1", bus.irq); end
        bus_write(2'd0, 32'($urandom_range(0, 255)));
        repeat (2) @(negedge clk);
        checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_busy got %b exp 0", bus.irq); end
        t = 0;
        while (bus.irq !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
        checks++; if (t >= 2000 || busy || tx_got_q.size() != 1) begin errors++; $display("FAIL irq_tx_idle_rise got irq %b busy %0d sent %0d exp 1 0 1", bus.irq, busy, tx_got_q.size()); end
        bus_write(2'd3, 32'd4);
        for (int i = 0; i < 17; i++) rx_inject(8'($urandom));
        repeat (2) @(negedge clk);
        checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL irq_ovf got %b exp 1", bus.irq); end
        bus_write(2'd1, 32'h20);
        rx_ovf_m = 0;
        @(negedge clk);
        checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_ovf_clear got %b exp 0", bus.irq); end
        while (exp_q.size() > 0) begin
            logic [7:0] b;
            bus_read(2'd0, d);
            b = exp_q.pop_front();
            checks++; if (d !== {24'd0, b}) begin errors++; $display("FAIL irq_drain_read got %h exp %h", d, b); end
        end
        bus_write(2'd3, 32'd0);
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d;
        int n0;
        clear_tx_model();
        model_run = 0;
        bus_write(2'd3, 32'd1);
        rx_inject(8'h5A);
        for (int i = 0; i < 4; i++) bus_write(2'd0, 32'($urandom_range(1, 255)));
        repeat (3) @(negedge clk);
        bus_read(2'd1, d);
        checks++; if (bus.irq !== 1'b1 || tx_got_q.size() != 1) begin errors++; $display("FAIL midframe_setup got irq %b sent %0d exp 1 1", bus.irq, tx_got_q.size()); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.rdata !== 32'd0) begin errors++; $display("FAIL arst_rdata got %h exp 0", bus.rdata); end
        checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL arst_irq got %b exp 0", bus.irq); end
        checks++; if (tx_data !== 8'd0) begin errors++; $display("FAIL arst_tx_data got %h exp 0", tx_data); end
        checks++; if (divisor !== 16'd27) begin errors++; $display("FAIL arst_divisor got %0d exp 27", divisor); end
        checks++; if (tx_state !== 1'b0) begin errors++; $display("FAIL arst_state got %b exp 0", tx_state); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        rx_ovf_m = 0;
        tx_ovf_m = 0;
        model_run = 1;
        n0 = tx_got_q.size();
        repeat (60) @(negedge clk);
        checks++; if (tx_got_q.size() != n0) begin errors++; $display("FAIL arst_no_tx got %0d exp %0d", tx_got_q.size(), n0); end
        bus_read(2'd1, d);
        checks++; if (d !== exp_status(0, 0, 1)) begin errors++; $display("FAIL arst_status got %h exp %h", d, exp_status(0, 0, 1)); end
        bus_read(2'd3, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL arst_irq_en got %h exp 0", d); end
    endtask

    initial begin
        bus.addr = 2'd0;
        bus.we = 1'b0;
        bus.re = 1'b0;
        bus.wdata = 32'd0;
        rx_data = 8'd0;
        rx_done = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_divisor();
        test_tx_basic();
        test_tx_overflow();
        test_rx();
        test_irq();
        test_reset_midframe();
        checks++; if (wr_busy_cnt != 0) begin errors++; $display("FAIL tx_wr_while_busy got %0d exp 0", wr_busy_cnt); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_ctrl.md
Name: uart_ctrl

Overview:
Register-mapped controller that sequences one uart_transceiver instance for the CPU bus.
- Buffers outgoing bytes in a TX FIFO and feeds them to the transceiver one at a time using the tx_wr/tx_done handshake.
- Captures every rx_done byte into an RX FIFO.
- Owns the baud divisor register and produces a level interrupt.
- Sits between the system bus decoder and the transceiver.

Parameters:
DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries, same for TX and RX.
DEFAULT_DIV, 16'd27, divisor reset value.

Ports:
sys_clk  in  1  system clock, all logic on rising edge
sys_rst_n  in  1  asynchronous active-low reset
addr  in  2  register select: 0 DATA, 1 STATUS, 2 DIVISOR, 3 IRQ_EN
we  in  1  write strobe, one cycle per access
re  in  1  read strobe, one cycle per access
wdata  in  32  write data
rdata  out  32  read data, registered
irq  out  1  level interrupt, registered
divisor  out  16  to transceiver divisor
tx_data  out  8  to transceiver tx_data
tx_wr  out  1  to transceiver tx_wr, one-cycle pulse
tx_done  in  1  from transceiver
rx_data  in  8  from transceiver
rx_done  in  1  from transceiver

Behaviour:
Reset (async, sys_rst_n=0):
- rdata=0, irq=0, tx_wr=0, tx_data=0, divisor=DEFAULT_DIV, IRQ_EN=0.
- Both FIFOs empty, sticky flags 0, TX FSM in T_IDLE.
- Assertion mid-frame aborts immediately; the queued byte is lost, no tx_wr follows.

Bus rules:
- we and re are never asserted in the same cycle.
- rdata updates on the edge after re; 1-cycle read latency. It holds its value otherwise.

DATA register:
- Write pushes wdata[7:0] into the TX FIFO. If the TX FIFO is full, the byte is dropped and tx_ovf is set.
- Read returns {24'b0, head} and pops the RX FIFO. If the RX FIFO is empty, the read returns 0 and nothing pops.

STATUS register (read):
- [0] rx_avail
- [1] rx_full
- [2] tx_full
- [3] tx_empty
- [4] tx_idle = TX FIFO empty and FSM in T_IDLE
- [5] rx_ovf (sticky)
- [6] tx_ovf (sticky)
- [8+DEPTH_LOG2:8] rx_count
- others 0

STATUS register (write): a 1 in bit 5 or bit 6 clears that sticky flag. A set and a clear in the same cycle leave the flag set.

DIVISOR register:
- Write loads wdata[15:0], effective immediately.
- Software must wait for tx_idle before changing it; no hardware interlock.
- Read returns the current value.

IRQ_EN register (bits 2:0, read/write):
- irq next = (rx_avail&en[0]) | (tx_idle&en[1]) | ((rx_ovf|tx_ovf)&en[2]).

FIFOs:
- Circular buffers with wrapping pointers and a count of DEPTH_LOG2+1 bits.
- Full = count == 2**DEPTH_LOG2.
- A simultaneous push and pop is accepted even when full (count unchanged) or empty (data passes through the next cycle; pop of an empty FIFO is still ignored).

RX capture:
- rx_done pushes rx_data.
- If the RX FIFO is full and no pop occurs that cycle, the byte is dropped and rx_ovf is set.

TX FSM:
- T_IDLE: when the TX FIFO is non-empty, register tx_data=head, tx_wr=1, pop the FIFO, go to T_WAIT.
- T_WAIT: tx_wr=0; on tx_done go to T_IDLE.
- Next-byte gap: tx_done in cycle N gives T_IDLE at N+1 and tx_wr at N+2.
- Latency: a DATA write at cycle N into an empty idle FIFO gives tx_wr at cycle N+2.
- tx_wr is never asserted while in T_WAIT.

Test Plan:
- Reset then read STATUS -> rdata=0x18 (tx_empty, tx_idle); read DIVISOR -> 27; irq=0.
- Write DATA 0x55 then 0xA3 with transceiver model (divisor 4) -> exactly two tx_wr pulses with tx_data 0x55 then 0xA3; second pulse exactly 2 cycles after first tx_done; uart_tx waveform matches 8N1.
- Write 17 bytes back-to-back while T_WAIT stalled (DEPTH_LOG2=4) -> 16 bytes queued: STATUS[2]=1 after the 16th write; after the 17th write STATUS[6]=1; write STATUS 0x40 -> bit 6 clears.
- Inject 17 rx_done bytes 0x00..0x10 without reads -> STATUS[1]=1, rx_count=16, rx_ovf=1; 16 DATA reads return 0x00..0x0F in order; 17th read returns 0, no pop.
- IRQ_EN=1, inject rx_done byte 0x3C -> irq=1 one cycle after the push; read DATA -> 0x3C, irq=0 one cycle after the pop. IRQ_EN=2 while draining TX -> irq rises when tx_idle.
- Assert sys_rst_n low mid-frame with 3 bytes queued -> all outputs at reset values asynchronously; after release no tx_wr, STATUS=0x18.
